alu_op_sequencer: RTL

//  Parametrised control sequencer for single-cycle-issue ALU instructions on the shared data bus.

---
 rtl/alu_op_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// Control sequencer for ADDI/SUBI/ADD/SUB on a shared data bus.
// Every output is decoded from the registered state and the latched instruction.
module alu_op_sequencer #(
  parameter int DATA_W   = 16,
  parameter int NREG     = 6,
  parameter int SIGN_EXT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       instr,
  input  logic              start,
  output logic              busy,
  output logic              pc_inc,
  output logic [NREG-1:0]   reg_out_sel,
  output logic [NREG-1:0]   reg_in_sel,
  output logic              imm_out_en,
  output logic [DATA_W-1:0] imm_value,
  output logic              alu_in1_en,
  output logic              alu_in2_en,
  output logic              alu_out_latch,
  output logic              alu_out_en,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LD1, S_LD2, S_EXEC, S_WB0, S_WB1, S_DONE, S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] instr_q, instr_d;

  logic [NREG-1:0]   p1_oh;
  logic [NREG-1:0]   p2_oh;
  logic [DATA_W-1:0] imm_ext;
  logic              reg_mode;

  function automatic logic is_legal(input logic [15:0] ins);
    logic imm_op;
    logic reg_op;
    imm_op = (ins[15:12] == 4'h1) || (ins[15:12] == 4'h2);
    reg_op = (ins[15:12] == 4'h3) || (ins[15:12] == 4'h4);
    return (imm_op || reg_op) &&
           ({1'b0, ins[11:6]} < 7'(NREG)) &&
           (!reg_op || ({1'b0, ins[5:0]} < 7'(NREG)));
  endfunction

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    case (state_q)
      // A new instruction may only be accepted from an idle or just-finished state.
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          instr_d = instr;
          state_d = is_legal(instr) ? S_FETCH : S_ERR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: state_d = S_LD1;
      S_LD1:   state_d = S_LD2;
      S_LD2:   state_d = S_EXEC;
      S_EXEC:  state_d = S_WB0;
      S_WB0:   state_d = S_WB1;
      S_WB1:   state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      p1_oh[i] = (instr_q[11:6] == 6'(i));
      p2_oh[i] = (instr_q[5:0] == 6'(i));
    end
    reg_mode = (instr_q[15:12] == 4'h3) || (instr_q[15:12] == 4'h4);
    if (SIGN_EXT != 0) imm_ext = DATA_W'($signed(instr_q[5:0]));
    else               imm_ext = DATA_W'(instr_q[5:0]);
  end

  always_comb begin
    busy          = (state_q != S_IDLE);
    pc_inc        = 1'b0;
    reg_out_sel   = '0;
    reg_in_sel    = '0;
    imm_out_en    = 1'b0;
    imm_value     = '0;
    alu_in1_en    = 1'b0;
    alu_in2_en    = 1'b0;
    alu_out_latch = 1'b0;
    alu_out_en    = 1'b0;
    done          = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_FETCH: begin
        pc_inc      = 1'b1;
        reg_out_sel = p1_oh;
      end
      S_LD1: begin
        reg_out_sel = p1_oh;
        alu_in1_en  = 1'b1;
      end
      // Second operand comes from the register file or the immediate, never both.
      S_LD2: begin
        alu_in2_en = 1'b1;
        if (reg_mode) begin
          reg_out_sel = p2_oh;
        end else begin
          imm_out_en = 1'b1;
          imm_value  = imm_ext;
        end
      end
      S_EXEC: alu_out_latch = 1'b1;
      S_WB0:  alu_out_en    = 1'b1;
      S_WB1: begin
        alu_out_en = 1'b1;
        reg_in_sel = p1_oh;
      end
      S_DONE: done = 1'b1;
      S_ERR: begin
        done    = 1'b1;
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
